sha256_msg_arbiter: RTL and testbench

- Shares one SHA-256 pipeline (byte-level preprocessor feeding a chunk processor) between NUM_REQ independent message sources.
- Grants the pipeline to one requester for a whole message, from first byte to bytes_done, and forwards that requester's byte stream.
- Waits for the final digest from the back end and returns it to the owning requester before re-arbitrating round-robin.

---
 rtl/sha256_msg_arbiter_if.sv | 47 ++++
 rtl/sha256_msg_arbiter.sv | 127 ++++++++++++
 tb/tb_sha256_msg_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_arbiter_if
// Brief    : Requester, preprocessor and digest signals of the shared
//            SHA-256 message arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sha256_msg_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ*8-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_byte_valid;
    logic [NUM_REQ-1:0]   req_bytes_done;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_digest_valid;
    logic [255:0]         digest_out;
    logic [7:0]           pp_byte;
    logic                 pp_byte_valid;
    logic                 pp_bytes_done;
    logic                 pp_ready_for_bytes;
    logic [255:0]         core_digest;
    logic                 core_digest_valid;
    logic [IDX_W-1:0]     owner;
    logic                 busy;
    logic                 err_spurious_digest;

    // Arbiter side
    modport slave (
        input  req_byte, req_byte_valid, req_bytes_done,
        input  pp_ready_for_bytes, core_digest, core_digest_valid,
        output req_ready, req_digest_valid, digest_out,
        output pp_byte, pp_byte_valid, pp_bytes_done,
        output owner, busy, err_spurious_digest
    );

    // Environment side (requesters plus SHA-256 back end)
    modport master (
        output req_byte, req_byte_valid, req_bytes_done,
        output pp_ready_for_bytes, core_digest, core_digest_valid,
        input  req_ready, req_digest_valid, digest_out,
        input  pp_byte, pp_byte_valid, pp_bytes_done,
        input  owner, busy, err_spurious_digest
    );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_arbiter
// Brief    : Round-robin, whole-message arbiter sharing one SHA-256 pipeline
//            between NUM_REQ byte-stream requesters and returning digests.
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    sha256_msg_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0]   c_num_req = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] c_last    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_STREAM      = 2'd1,
        S_WAIT_DIGEST = 2'd2,
        S_DELIVER     = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_owner;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [255:0]     r_digest;
    logic             r_err;

    logic [7:0]         w_bytes [NUM_REQ];
    logic               w_stream;
    logic               w_own_valid;
    logic               w_xfer;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W:0]     w_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [NUM_REQ-1:0] w_dv;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = bus.req_byte[8*gi +: 8];
    end

    assign w_stream    = (r_state == S_STREAM);
    assign w_own_valid = w_stream & bus.req_byte_valid[r_owner];
    assign w_xfer      = w_own_valid & bus.pp_ready_for_bytes;

    // Scan from rr_ptr upwards with wrap; descending loop lets the nearest hit win.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rr_ptr;
        w_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_idx >= c_num_req) begin
                w_idx = w_idx - c_num_req;
            end
            if (bus.req_byte_valid[w_idx[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_dv    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i] = w_stream && (r_owner == IDX_W'(i)) && bus.pp_ready_for_bytes;
            w_dv[i]    = (r_state == S_DELIVER) && (r_owner == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_digest <= '0;
            r_err    <= 1'b0;
        end else begin
            if (bus.core_digest_valid && (r_state != S_WAIT_DIGEST)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_xfer && bus.req_bytes_done[r_owner]) begin
                        r_state <= S_WAIT_DIGEST;
                    end
                end
                S_WAIT_DIGEST: begin
                    if (bus.core_digest_valid) begin
                        r_digest <= bus.core_digest;
                        r_rr_ptr <= (r_owner == c_last) ? '0 : r_owner + 1'b1;
                        r_state  <= S_DELIVER;
                    end
                end
                S_DELIVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pp_byte             = w_stream ? w_bytes[r_owner] : 8'h00;
    assign bus.pp_byte_valid       = w_own_valid;
    assign bus.pp_bytes_done       = w_stream & bus.req_bytes_done[r_owner];
    assign bus.req_ready           = w_ready;
    assign bus.req_digest_valid    = w_dv;
    assign bus.digest_out          = r_digest;
    assign bus.owner               = r_owner;
    assign bus.busy                = (r_state != S_IDLE);
    assign bus.err_spurious_digest = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_arbiter
// Brief    : Self-checking bench: grant tables, corner sequences and random
//            traffic against a message-level model of the shared pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_arbiter;
    localparam int N = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_arbiter_if #(.NUM_REQ(N)) bus ();
    sha256_msg_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [N-1:0] mask;
        int           len;
        logic [7:0]   ord;
    } vec_t;
    vec_t vecs [7];

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]   src_q [N][$];
    logic [N-1:0] hold, outst;
    bit           rdy, spur;
    bit           m_free, m_wait, m_deliver, m_err;
    int           m_owner, m_ptr, m_xfers, m_len;
    logic [255:0] m_digest;
    int           be_cnt, be_lat;
    logic [255:0] be_val, be_fixed;
    bit           be_fixed_en;
    int           cyc, n_xfer, n_deliv;
    int           pulse_cnt [N];
    int           pulse_cyc [N];
    int           grant_cyc [N];
    int           grant_log [$];

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int glog(int k);
        return (k < grant_log.size()) ? grant_log[k] : -1;
    endfunction

    task automatic model_reset();
        m_free = 1; m_wait = 0; m_deliver = 0; m_err = 0;
        m_owner = 0; m_ptr = 0; m_xfers = 0; m_len = 0; m_digest = '0;
        be_cnt = 0; outst = '0; hold = '0; spur = 0;
        for (int i = 0; i < N; i++) src_q[i].delete();
    endtask

    task automatic load(int i, int len, bit seq);
        for (int k = 0; k < len; k++) src_q[i].push_back(seq ? 8'(k) : 8'($urandom));
        outst[i] = 1'b1;
    endtask

    // One clock of the environment: drive, check at negedge, update model after posedge.
    task automatic cycle();
        logic [N-1:0] v;
        logic         cdv;
        logic [255:0] cd;
        bit           stream, xfer, last;
        int           pick;
        cyc++;
        v = '0;
        bus.req_byte       = '0;
        bus.req_bytes_done = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                v[i] = 1'b1;
                bus.req_byte[8*i +: 8] = src_q[i][0];
                bus.req_bytes_done[i]  = (src_q[i].size() == 1);
            end
        end
        bus.req_byte_valid     = v;
        bus.pp_ready_for_bytes = rdy;
        cdv = spur || (be_cnt == 1);
        cd  = (be_cnt == 1) ? be_val : {8{$urandom}};
        bus.core_digest_valid = cdv;
        bus.core_digest       = cd;

        @(negedge clk);
        stream = !m_free && !m_wait && !m_deliver;
        chk("busy", bus.busy, !m_free);
        chk("req_ready", bus.req_ready, (stream && rdy) ? onehot(m_owner) : '0);
        chk("req_digest_valid", bus.req_digest_valid, m_deliver ? onehot(m_owner) : '0);
        chk("digest_out", bus.digest_out, m_digest);
        chk("err_spurious", bus.err_spurious_digest, m_err);
        chk("pp_byte_valid", bus.pp_byte_valid, stream && v[m_owner]);
        if (stream && v[m_owner]) begin
            chk("pp_byte", bus.pp_byte, src_q[m_owner][0]);
            chk("pp_bytes_done", bus.pp_bytes_done, src_q[m_owner].size() == 1);
        end else if (!stream) begin
            chk("pp_bytes_done_idle", bus.pp_bytes_done, 0);
        end
        if (m_deliver) begin
            pulse_cyc[m_owner] = cyc;
            pulse_cnt[m_owner]++;
        end
        xfer = stream && v[m_owner] && rdy;
        pick = -1;
        if (m_free) begin
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && v[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            end
        end

        @(posedge clk);
        #1;
        if (be_cnt > 0) be_cnt--;
        if (cdv && !m_wait) m_err = 1;
        if (m_deliver) begin
            m_deliver = 0; m_free = 1; outst[m_owner] = 1'b0; n_deliv++;
        end else if (m_wait && cdv) begin
            m_wait = 0; m_deliver = 1; m_digest = cd; m_ptr = (m_owner + 1) % N;
        end
        if (pick >= 0) begin
            m_free = 0; m_owner = pick; m_xfers = 0; m_len = src_q[pick].size();
            grant_log.push_back(pick);
            grant_cyc[pick] = cyc;
            chk("owner", bus.owner, pick);
        end
        if (xfer) begin
            last = (src_q[m_owner].size() == 1);
            void'(src_q[m_owner].pop_front());
            m_xfers++;
            n_xfer++;
            if (last) begin
                chk("msg_len", m_xfers, m_len);
                m_wait = 1;
                be_cnt = be_lat;
                be_val = be_fixed_en ? be_fixed : {8{$urandom}};
            end
        end
    endtask

    task automatic drain(int budget);
        int k = 0;
        while ((outst != '0 || !m_free) && k < budget) begin
            cycle();
            k++;
        end
        chk("drain_timeout", (outst != '0 || !m_free), 0);
    endtask

    task automatic run_until_stream(int who, int nbytes, int budget);
        int k = 0;
        while (!(!m_free && !m_wait && !m_deliver && m_owner == who && m_xfers >= nbytes)
               && k < budget) begin
            cycle();
            k++;
        end
        chk("stream_wait_timeout", k >= budget, 0);
    endtask

    task automatic do_reset(bit check);
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (check) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_pp_byte_valid", bus.pp_byte_valid, 0);
            chk("rst_pp_bytes_done", bus.pp_bytes_done, 0);
            chk("rst_pp_byte", bus.pp_byte, 0);
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_digest_valid", bus.req_digest_valid, 0);
            chk("rst_digest_out", bus.digest_out, 0);
            chk("rst_err", bus.err_spurious_digest, 0);
            chk("rst_owner", bus.owner, 0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{mask: 4'b1111, len: 1, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{mask: 4'b1111, len: 2, ord: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[2] = '{mask: 4'b1010, len: 1, ord: {2'd0, 2'd0, 2'd3, 2'd1}};
        vecs[3] = '{mask: 4'b0101, len: 3, ord: {2'd0, 2'd0, 2'd2, 2'd0}};
        vecs[4] = '{mask: 4'b0110, len: 2, ord: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[5] = '{mask: 4'b1001, len: 1, ord: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[6] = '{mask: 4'b0001, len: 1, ord: {2'd0, 2'd0, 2'd0, 2'd0}};

        bus.req_byte = '0; bus.req_byte_valid = '0; bus.req_bytes_done = '0;
        bus.pp_ready_for_bytes = 1'b0; bus.core_digest = '0; bus.core_digest_valid = 1'b0;
        cyc = 0; n_xfer = 0; n_deliv = 0; rdy = 1; be_lat = 2; be_fixed_en = 0; be_fixed = '0;
        be_val = '0;
        for (int i = 0; i < N; i++) begin
            pulse_cnt[i] = 0; pulse_cyc[i] = 0; grant_cyc[i] = 0;
        end
        model_reset();
        do_reset(1);

        // "abc" on requester 2 with its known SHA-256 digest
        be_fixed_en = 1;
        be_fixed = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        src_q[2].push_back(8'h61); src_q[2].push_back(8'h62); src_q[2].push_back(8'h63);
        outst[2] = 1'b1;
        n_xfer = 0;
        drain(200);
        chk("abc_grant", glog(0), 2);
        chk("abc_owner", bus.owner, 2);
        chk("abc_xfers", n_xfer, 3);
        chk("abc_pulses", pulse_cnt[2], 1);
        chk("abc_digest", bus.digest_out, be_fixed);
        chk("abc_busy", bus.busy, 0);
        be_fixed_en = 0;

        // Grant-order table from reset
        do_reset(0);
        for (int t = 0; t < 7; t++) begin
            grant_log.delete();
            for (int i = 0; i < N; i++) if (vecs[t].mask[i]) load(i, vecs[t].len, 0);
            drain(500);
            chk("vec_grant_count", grant_log.size(), $countones(vecs[t].mask));
            for (int k = 0; k < $countones(vecs[t].mask); k++) begin
                chk("vec_grant_order", glog(k), vecs[t].ord[2*k +: 2]);
            end
        end

        // Backpressure: 64-byte message, ready low 5 cycles after byte 20
        load(1, 64, 1);
        run_until_stream(1, 20, 400);
        rdy = 0;
        repeat (5) begin
            cycle();
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_valid_held", bus.pp_byte_valid, 1);
            chk("bp_byte_held", bus.pp_byte, 8'd20);
        end
        rdy = 1;
        drain(400);
        chk("bp_total_xfers", m_xfers, 64);

        // Spurious digest while idle
        do_reset(0);
        spur = 1;
        cycle();
        spur = 0;
        repeat (3) begin
            cycle();
            chk("spur_err_held", bus.err_spurious_digest, 1);
            chk("spur_digest_out", bus.digest_out, 0);
            chk("spur_no_pulse", bus.req_digest_valid, 0);
        end

        // Reset in the middle of a message; pointer must return to 0
        do_reset(1);
        load(1, 1, 0);
        drain(100);
        load(2, 20, 1);
        run_until_stream(2, 10, 200);
        do_reset(1);
        grant_log.delete();
        load(0, 3, 0);
        load(3, 3, 0);
        drain(200);
        chk("rst_regrant_first", glog(0), 0);
        chk("rst_regrant_req3", glog(1), 3);

        // Contention: requester 1 waits while requester 3 is served
        grant_log.delete();
        load(3, 6, 0);
        run_until_stream(3, 0, 50);
        load(1, 4, 0);
        drain(300);
        chk("cont_first", glog(0), 3);
        chk("cont_second", glog(1), 1);
        chk("cont_gap", grant_cyc[1], pulse_cyc[3] + 1);

        // Random traffic against the model
        do_reset(0);
        n_deliv = 0;
        for (int t = 0; t < 4000 && n_deliv < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!outst[i] && $urandom_range(0, 4) == 0) load(i, $urandom_range(1, 10), 0);
            end
            rdy    = ($urandom_range(0, 3) != 0);
            hold   = N'($urandom) & N'($urandom) & N'($urandom);
            be_lat = $urandom_range(1, 5);
            if (m_free && $urandom_range(0, 40) == 0) spur = 1;
            cycle();
            spur = 0;
        end
        rdy = 1;
        hold = '0;
        drain(2000);
        chk("rand_deliveries", n_deliv >= 60, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
